// File: rtl/dmem_ctrl.sv
`default_nettype none
// dmem_ctrl: load/store sequencer to word-wide data memory (RMW for SB/SH, load extension).
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned H/W returns an error instead of aligning down. Rev 1.0
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_data_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAPT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic        legal;
  logic        trap;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        unused_addr;

  assign unused_addr = ^req_addr_i[31:ADDR_WIDTH];

  assign legal = req_store_i ? (req_funct3_i[2] == 1'b0 && req_funct3_i[1:0] != 2'b11)
                             : (req_funct3_i[1:0] != 2'b11 && req_funct3_i[2:1] != 2'b11);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                      (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
  assign trap = misaligned;
`else
  assign trap = 1'b0;
`endif

  // Lane selection uses the captured offset; H ignores off[0] so misaligned halves align down.
  always_comb begin
    case (off_q)
      2'd0:    byte_lane = mem_rdata_i[7:0];
      2'd1:    byte_lane = mem_rdata_i[15:8];
      2'd2:    byte_lane = mem_rdata_i[23:16];
      default: byte_lane = mem_rdata_i[31:24];
    endcase
    half_lane = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    case (funct3_q)
      3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_val = {24'b0, byte_lane};
      3'b101:  load_val = {16'b0, half_lane};
      default: load_val = mem_rdata_i;
    endcase

    merged = mem_rdata_i;
    if (funct3_q[0]) begin
      if (off_q[1]) merged[31:16] = wdata_q;
      else          merged[15:0]  = wdata_q;
    end else begin
      case (off_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'b0;
      off_q       <= 2'b0;
      wdata_q     <= 16'b0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 32'b0;
      rsp_err_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_re_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            store_q     <= req_store_i;
            funct3_q    <= req_funct3_i;
            off_q       <= req_addr_i[1:0];
            wdata_q     <= req_wdata_i[15:0];
            mem_addr_o  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
            req_ready_o <= 1'b0;
            if (!legal || trap) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_data_o  <= 32'b0;
            end else if (req_store_i && req_funct3_i[1:0] == 2'b10) begin
              state       <= WR;
              mem_we_o    <= 1'b1;
              mem_wdata_o <= req_wdata_i;
            end else begin
              state    <= RD;
              mem_re_o <= 1'b1;
            end
          end
        end
        RD: begin
          mem_re_o <= 1'b0;
          state    <= CAPT;
        end
        CAPT: begin
          if (store_q) begin
            mem_wdata_o <= merged;
            mem_we_o    <= 1'b1;
            state       <= WR;
          end else begin
            rsp_data_o  <= load_val;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end
        end
        WR: begin
          mem_we_o    <= 1'b0;
          rsp_data_o  <= 32'b0;
          rsp_err_o   <= 1'b0;
          rsp_valid_o <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= 32'b0;
            rsp_err_o   <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          mem_re_o    <= 1'b0;
          mem_we_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl against a byte-level memory model.
module tb_dmem_ctrl;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_store = 1'b0;
  logic [2:0]    req_funct3 = 3'b0;
  logic [31:0]   req_addr = 32'b0;
  logic [31:0]   req_wdata = 32'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Word memory seen by the DUT, and the byte-addressed reference image.
  logic [31:0] mem  [0:255]  = '{default: 32'h0};
  logic [7:0]  rmem [0:1023] = '{default: 8'h0};

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] last_waddr, last_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] ed, output logic ee,
                       output int lat);
    int a, size;
    logic legal;
    logic [31:0] v;
    a = int'(addr[9:0]);
    legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
    size = 1 << f3[1:0];
    ed = 32'h0;
    ee = 1'b0;
    lat = 1;
    if (!legal) begin
      ee = 1'b1;
      return;
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((a % size) != 0) begin
      ee = 1'b1;
      return;
    end
`endif
    a = a - (a % size);
    if (st) begin
      for (int i = 0; i < size; i++) rmem[a + i] = wd[8*i +: 8];
      lat = (size == 4) ? 2 : 4;
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(rmem[a + i]) << (8 * i));
      if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      ed = v;
      lat = 3;
    end
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int bp,
                        output logic [31:0] got, output logic got_err);
    logic [31:0] ed;
    logic ee, saw_re, saw_we, bad, stable_bad;
    int lat, n;
    model(st, f3, addr, wd, ed, ee, lat);
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    n = 0; saw_re = 1'b0; saw_we = 1'b0; bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (mem_re) saw_re = 1'b1;
      if (mem_we) begin
        saw_we = 1'b1;
        last_waddr = 32'(mem_addr);
        last_wdata = mem_wdata;
      end
      if (mem_re && mem_we) bad = 1'b1;
    end while (!rsp_valid && n < 20);
    check("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
    check("latency", n, lat);
    check("rsp_data", rsp_data, ed);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, ee});
    check("re_we_excl", {31'b0, bad}, 32'd0);
    if (ee) check("no_mem_on_err", {31'b0, saw_re | saw_we}, 32'd0);
    got = rsp_data;
    got_err = rsp_err;
    stable_bad = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (rsp_data !== got || rsp_err !== got_err || !rsp_valid || req_ready || mem_re || mem_we)
        stable_bad = 1'b1;
    end
    if (bp > 0) check("bp_stable", {31'b0, stable_bad}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("retired", {31'b0, rsp_valid}, 32'd0);
  endtask

  logic [31:0] got;
  logic        gerr;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_strobes", {30'b0, mem_re, mem_we}, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // SW with a 2-cycle latency and a visible write cycle.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, got, gerr);
    check("sw_waddr", last_waddr, 32'h10);
    check("sw_wdata", last_wdata, 32'hDEADBEEF);
    check("sw_rsp", got, 32'h0);

    do_req(1'b1, 3'b010, 32'h20, 32'h80FF7F01, 0, got, gerr);
    do_req(1'b0, 3'b000, 32'h23, 32'h0, 0, got, gerr);  check("lb_23", got, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h23, 32'h0, 0, got, gerr);  check("lbu_23", got, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h22, 32'h0, 5, got, gerr);  check("lh_22", got, 32'hFFFF80FF);
    do_req(1'b0, 3'b101, 32'h20, 32'h0, 0, got, gerr);  check("lhu_20", got, 32'h00007F01);

    do_req(1'b1, 3'b010, 32'h30, 32'h11223344, 0, got, gerr);
    do_req(1'b1, 3'b000, 32'h31, 32'h000000AA, 0, got, gerr);
    check("sb_merge", last_wdata, 32'h1122AA44);
    do_req(1'b1, 3'b010, 32'h30, 32'h11223344, 0, got, gerr);
    do_req(1'b1, 3'b001, 32'h32, 32'h00005566, 0, got, gerr);
    check("sh_merge", last_wdata, 32'h55663344);

    do_req(1'b0, 3'b011, 32'h20, 32'h0, 0, got, gerr);
    check("illegal_err", {31'b0, gerr}, 32'd1);
    do_req(1'b0, 3'b010, 32'h22, 32'h0, 0, got, gerr);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw_22_trap", {31'b0, gerr}, 32'd1);
`else
    check("lw_22_down", got, 32'h80FF7F01);
`endif

    // Reset in the middle of a read.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("re_in_rd", {31'b0, mem_re}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrd_ready", {31'b0, req_ready}, 32'd1);
    check("midrd_re", {31'b0, mem_re}, 32'd0);
    check("midrd_rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Reset during the capture cycle of an SB must not write.
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'hCC;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, got, gerr);
    check("no_partial_rmw", got, 32'h80FF7F01);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, got, gerr);
    end

    for (int w = 0; w < 32; w++)
      check("mem_image", mem[w], {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
